pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
- Multi-channel PWM generator; successor to the single-channel pwm block.
- One shared period counter drives CH compare channels.
- Adds double-buffered (shadowed) period/duty updates applied only at period boundaries, edge- or center-aligned mode, per-channel output polarity, and a period-start strobe for fabric/MSS sync.

Parameters:
- CH, 4, number of PWM output channels (1..16)
- W, 16, counter/period/duty width in bits (4..32)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- enable  in  1  run counter; low = outputs idle, counter held
- center  in  1  0 = edge-aligned, 1 = center-aligned (sampled only at period boundary or while disabled)
- period  in  W  requested period value P
- duty  in  CH*W  requested duty per channel; channel i = duty[i*W +: W]
- update  in  1  one-cycle request to capture period/duty/center into shadow
- polarity  in  CH  per-channel invert, applied immediately (not shadowed)
- pwm_out  out  CH  registered PWM outputs
- period_start  out  1  one-cycle pulse when counter is at 0 on the up-count
- update_ack  out  1  one-cycle pulse when shadow values become active

Behaviour:
- One clock, clk; reset synchronous, active-low on rst_n.
- Reset (rst_n=0 at a clk edge):
  - cnt=0, dir=up, active_period=0, active_duty=0, active_center=0, pending=0.
  - pwm_out=0, period_start=0, update_ack=0.
- Registers:
  - Shadow: period/duty/center plus pending flag.
  - Active: the copies the comparator uses.
- Update capture:
  - update=1 writes shadow and sets pending.
  - A second update before apply overwrites shadow; only one ack is produced.
- Apply point: the edge where the counter returns to 0, i.e. the wrap cycle. At that edge, active <= shadow, pending cleared, and update_ack=1 in the following cycle.
  - If update=1 on the wrap cycle itself, the fresh inputs bypass straight to active and are acked.
- enable=0:
  - cnt held 0, dir=up, period_start=0.
  - A pending update applies on the next edge (ack pulses).
  - pwm_out = polarity (inactive level) from the next cycle.
- Edge mode:
  - cnt sequence 0,1,...,P-1,0; period P cycles.
  - Wrap cycle = cnt==P-1.
- Center mode:
  - cnt sequence 0,1,...,P,P-1,...,1,0; period 2P cycles.
  - dir flips at cnt==P (to down) and at cnt==1 while down (wrap).
- Compare: raw_i = (cnt < active_duty_i). pwm_out_i <= raw_i XOR polarity_i, so one cycle latency from cnt.
- period_start: registered. It is 1 in the cycle after cnt==0 with dir=up and enable=1, aligned with pwm_out.
- Boundaries:
  - active_period==0: counter held 0, raw=0 for all channels, period_start never pulses, pending still applies each cycle (wrap condition true).
  - duty==0: output constantly inactive.
  - Edge mode, duty>=P: constantly active (100%).
  - Center mode, duty>P: constantly active.
  - Edge mode, P==1: cnt stays 0 and wraps every cycle.
- enable rising: counting starts from cnt=0 with the current active values; the first period_start follows one cycle later.
- Reset mid-period: immediate return to the reset state at that edge; pending is discarded.
- All arithmetic is unsigned, W bits.
- Compares are on full W bits. In center mode P must be <= 2^W-1 (caller's responsibility); the counter never exceeds P.

Decomposition:
- Package pwm_pkg holds: mode constants (PWM_EDGE=0, PWM_CENTER=1), default widths, and a function extracting channel slice i from the packed duty bus.
- One natural sub-module, pwm_cmp_ch: per-channel comparator + polarity + output register, instantiated CH times via generate.
- The counter, direction FSM (UP/DOWN), and shadow/pending logic stay in pwm_multi.

Test Plan:
- Edge, W=8, CH=4, P=10, duty={0,3,10,12}, polarity=0 → ch0 always 0; ch1 high 3 of 10 cycles; ch2 and ch3 always 1; period_start every 10 cycles.
- Center, P=8, duty ch1=4 → period 16 cycles; ch1 high 7 cycles centered on cnt=0 (cnt 3,2,1,0,1,2,3); period_start every 16 cycles.
- Running P=10 duty=5; update to P=20 duty=2 at mid-period (cnt=4) → old waveform completes to cnt=9; new values from the next cnt=0; update_ack one pulse at the boundary.
- Two update pulses before the boundary (duty 2 then 7) → only 7 applied; exactly one update_ack.
- polarity toggled mid-period; enable dropped → output inverts next cycle; with enable low, outputs = polarity and the counter is held 0.
- rst_n low mid-period with update pending → all outputs 0 next cycle; after release, no ack and active period=0 (outputs idle).

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
package pwm_pkg;

  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  localparam int DEF_CH = 4;
  localparam int DEF_W  = 16;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Channel i of a packed duty bus (zero-extended, up to 16x32 bits).
  function automatic logic [31:0] duty_slice(
    input logic [511:0] bus,
    input int           i,
    input int           w
  );
    return 32'(bus >> (i * w));
  endfunction

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: compare against the shared counter, apply
// polarity and register the result.
module pwm_cmp_ch
  import pwm_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         pol,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] duty,
  output logic         pwm_out
);

  logic pwm_d, pwm_q;

  always_comb begin
    pwm_d = (en && (cnt < duty)) ^ pol;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_q <= 1'b0;
    else        pwm_q <= pwm_d;
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared up/up-down counter with shadowed
// period/duty/mode that take effect only at period boundaries.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH = DEF_CH,
  parameter int W  = DEF_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          center,
  input  logic [W-1:0]  period,
  input  logic [CH*W-1:0] duty,
  input  logic          update,
  input  logic [CH-1:0] polarity,
  output logic [CH-1:0] pwm_out,
  output logic          period_start,
  output logic          update_ack
);

  logic [W-1:0]    cnt_d, cnt_q;
  dir_e            dir_d, dir_q;
  logic [W-1:0]    act_period_d, act_period_q;
  logic [CH*W-1:0] act_duty_d, act_duty_q;
  logic            act_center_d, act_center_q;
  logic [W-1:0]    sh_period_d, sh_period_q;
  logic [CH*W-1:0] sh_duty_d, sh_duty_q;
  logic            sh_center_d, sh_center_q;
  logic            pending_d, pending_q;
  logic            ack_d, ack_q;
  logic            ps_d, ps_q;
  logic            p_nz, wrap, apply;

  assign p_nz = (act_period_q != '0);

  always_comb begin
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    act_center_d = act_center_q;
    sh_period_d  = sh_period_q;
    sh_duty_d    = sh_duty_q;
    sh_center_d  = sh_center_q;
    pending_d    = pending_q;
    ack_d        = 1'b0;
    wrap         = 1'b0;

    // Period 1 in center mode runs 0,1,0 and wraps from the top.
    if (!p_nz) begin
      wrap = 1'b1;
    end else if (act_center_q == PWM_CENTER) begin
      wrap = ((dir_q == DIR_DOWN) && (cnt_q <= W'(1)))
          || ((dir_q == DIR_UP) && (act_period_q == W'(1))
              && (cnt_q >= W'(1)));
    end else begin
      wrap = (cnt_q >= act_period_q - W'(1));
    end
    apply = !enable || wrap;

    if (apply) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (act_center_q == PWM_CENTER) begin
      if (dir_q == DIR_UP) begin
        if (cnt_q >= act_period_q) begin
          cnt_d = act_period_q - W'(1);
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end else begin
      cnt_d = cnt_q + W'(1);
    end

    if (update) begin
      sh_period_d = period;
      sh_duty_d   = duty;
      sh_center_d = center;
      pending_d   = 1'b1;
    end

    if (apply && update) begin
      act_period_d = period;
      act_duty_d   = duty;
      act_center_d = center;
      pending_d    = 1'b0;
      ack_d        = 1'b1;
    end else if (apply && pending_q) begin
      act_period_d = sh_period_q;
      act_duty_d   = sh_duty_q;
      act_center_d = sh_center_q;
      pending_d    = 1'b0;
      ack_d        = 1'b1;
    end

    ps_d = enable && p_nz && (cnt_q == '0) && (dir_q == DIR_UP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      act_period_q <= '0;
      act_duty_q   <= '0;
      act_center_q <= PWM_EDGE;
      sh_period_q  <= '0;
      sh_duty_q    <= '0;
      sh_center_q  <= PWM_EDGE;
      pending_q    <= 1'b0;
      ack_q        <= 1'b0;
      ps_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      act_center_q <= act_center_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      sh_center_q  <= sh_center_d;
      pending_q    <= pending_d;
      ack_q        <= ack_d;
      ps_q         <= ps_d;
    end
  end

  assign period_start = ps_q;
  assign update_ack   = ack_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] duty_i;
    assign duty_i = W'(duty_slice(512'(act_duty_q), i, W));

    pwm_cmp_ch #(.W(W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (enable && p_nz),
      .pol     (polarity[i]),
      .cnt     (cnt_q),
      .duty    (duty_i),
      .pwm_out (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (CH=4, W=8).
module tb_pwm_multi;

  localparam int CH = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          center;
  logic [W-1:0]  period;
  logic [CH*W-1:0] duty;
  logic          update;
  logic [CH-1:0] polarity;
  logic [CH-1:0] pwm_out;
  logic          period_start;
  logic          update_ack;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwm_multi #(.CH(CH), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .center       (center),
    .period       (period),
    .duty         (duty),
    .update       (update),
    .polarity     (polarity),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .update_ack   (update_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] raw(input int c, input logic [31:0] d);
    logic [3:0] r;
    for (int ch = 0; ch < 4; ch++)
      r[ch] = (c < int'(d[ch*8 +: 8]));
    return r;
  endfunction

  // Disable, load values immediately (applies while disabled), re-enable.
  task automatic load(input int p, input logic [31:0] d, input logic ctr);
    enable = 1'b0;
    update = 1'b0;
    tick();
    chk("idle_pwm", pwm_out, polarity);
    period = W'(p);
    duty   = d;
    center = ctr;
    update = 1'b1;
    tick();
    chk("load_ack", update_ack, 1);
    update = 1'b0;
    enable = 1'b1;
  endtask

  // Edge-mode run; old values until wrap edge kb, new values afterwards.
  task automatic run_edge(input int n,
                          input int p0, input logic [31:0] d0,
                          input int kb,
                          input int p1, input logic [31:0] d1,
                          input int ku1, input logic [31:0] du1,
                          input int ku2, input logic [31:0] du2,
                          input int pu);
    int c;
    logic [31:0] d;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k <= kb) begin
        c = (k - 1) % p0;
        d = d0;
      end else begin
        c = (k - kb - 1) % p1;
        d = d1;
      end
      chk("edge_pwm", pwm_out, raw(c, d) ^ polarity);
      chk("edge_ps", period_start, c == 0);
      chk("edge_ack", update_ack, k == kb);
      update = 1'b0;
      if (k == ku1) begin
        update = 1'b1; duty = du1; period = W'(pu);
      end else if (k == ku2) begin
        update = 1'b1; duty = du2; period = W'(pu);
      end
    end
    update = 1'b0;
  endtask

  logic [31:0] d5, d2, d7, dA, dC, d1;
  int idx, c;

  initial begin
    d5 = {4{8'd5}};
    d2 = {4{8'd2}};
    d7 = {4{8'd7}};
    d1 = {4{8'd1}};
    dA = {8'd12, 8'd10, 8'd3, 8'd0};
    dC = {8'd9, 8'd0, 8'd4, 8'd2};

    rst_n = 1'b0; enable = 1'b0; center = 1'b0;
    period = '0; duty = '0; update = 1'b0; polarity = '0;
    tick();
    tick();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ps", period_start, 0);
    chk("rst_ack", update_ack, 0);
    rst_n = 1'b1;

    // Edge mode, mixed duties including 0, ==P and >P.
    load(10, dA, 1'b0);
    run_edge(20, 1, 0, 0, 10, dA, 0, 0, 0, 0, 0);

    // Update mid-period (cnt=4), takes effect after cnt=9.
    load(10, d5, 1'b0);
    run_edge(32, 10, d5, 10, 20, d2, 4, d2, 0, 0, 20);

    // Two updates in one period: last one wins, one ack.
    load(10, d5, 1'b0);
    run_edge(25, 10, d5, 10, 10, d7, 2, d2, 5, d7, 10);

    // Center mode, P=8: period 16, ch1 high for 7 cycles.
    load(8, dC, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      tick();
      idx = (k - 1) % 16;
      c   = (idx <= 8) ? idx : 16 - idx;
      chk("ctr_pwm", pwm_out, raw(c, dC));
      chk("ctr_ps", period_start, idx == 0);
      chk("ctr_ack", update_ack, 0);
    end

    // Polarity change shows next cycle (counter now at 2).
    polarity = 4'b0101;
    tick();
    chk("pol_pwm", pwm_out, 4'b1111);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("dis_pwm", pwm_out, 4'b0101);
      chk("dis_ps", period_start, 0);
      chk("dis_cnt", dut.cnt_q, 0);
    end

    // Reset with an update pending: pending is dropped.
    load(10, d5, 1'b0);
    tick();
    tick();
    tick();
    update = 1'b1; period = 8'd20; duty = d2;
    tick();
    update = 1'b0;
    rst_n  = 1'b0;
    tick();
    chk("mrst_pwm", pwm_out, 0);
    chk("mrst_ps", period_start, 0);
    chk("mrst_ack", update_ack, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("p0_pwm", pwm_out, 4'b0101);
      chk("p0_ps", period_start, 0);
      chk("p0_ack", update_ack, 0);
      chk("p0_cnt", dut.cnt_q, 0);
    end

    // P==0 applies an enabled update on the next edge; then P==1.
    update = 1'b1; period = 8'd1; duty = d1; center = 1'b0;
    tick();
    update = 1'b0;
    chk("p1_ack", update_ack, 1);
    chk("p1_ps0", period_start, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("p1_pwm", pwm_out, 4'b1010);
      chk("p1_ps", period_start, 1);
      chk("p1_ack0", update_ack, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
